// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB transmitter: default field widths and the
// round-robin helper. A CDB entry is packed {branch_taken, branch, data, tag},
// MSB to LSB, TAG_W + DATA_W + 2 bits wide.
package cdb_arbiter_pkg;

    localparam int CDB_TAG_W   = 5;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_ENTRY_W = CDB_TAG_W + CDB_DATA_W + 2;

    // Index following idx in a ring of n slots.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-FU result queue: DEPTH-entry synchronous FIFO with flush.
// Pointers wrap naturally because DEPTH is a power of two; count spans 0..DEPTH.
module cdb_fu_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Next pointer/count state; flush empties the queue outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: per-FU result queues, round-robin pick of one non-empty
// queue per cycle, registered broadcast. Arbitration sees registered queue
// state only, so an entry is broadcast no earlier than the edge after its push.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_FU   = 4,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [N_FU-1:0]        fu_valid,
    output logic [N_FU-1:0]        fu_ready,
    input  logic [N_FU*TAG_W-1:0]  fu_rd_tag,
    input  logic [N_FU*DATA_W-1:0] fu_data,
    input  logic [N_FU-1:0]        fu_branch,
    input  logic [N_FU-1:0]        fu_branch_taken,
    output logic                   Cdb_valid,
    output logic [TAG_W-1:0]       Cdb_rd_tag,
    output logic [DATA_W-1:0]      Cdb_data,
    output logic                   Cdb_branch,
    output logic                   Cdb_branch_taken,
    output logic                   cdb_pending
);

    localparam int ENTRY_W = TAG_W + DATA_W + 2;
    localparam int RR_W    = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]    full, empty, push, pop;
    logic [ENTRY_W-1:0] head [N_FU];

    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [ENTRY_W-1:0] cdb_entry_q, cdb_entry_d;
    logic               found;
    logic [RR_W-1:0]    win_idx;
    int                 idx;

    // Ready depends only on registered fill level and flush: no pop-to-ready path.
    assign fu_ready    = ~full & {N_FU{~flush}};
    assign push        = fu_valid & fu_ready;
    assign cdb_pending = ~&empty;

    for (genvar i = 0; i < N_FU; i++) begin : g_fifo
        cdb_fu_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata ({fu_branch_taken[i], fu_branch[i],
                     fu_data[i*DATA_W +: DATA_W], fu_rd_tag[i*TAG_W +: TAG_W]}),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    // Round-robin pick from rr_ptr upward, pop of the winner, next broadcast.
    always_comb begin
        found       = 1'b0;
        win_idx     = '0;
        idx         = 0;
        pop         = '0;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_entry_d = '0;
        for (int k = 0; k < N_FU; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_FU;
            if (!found && !empty[idx]) begin
                found   = 1'b1;
                win_idx = RR_W'(idx);
            end
        end
        if (found && !flush) begin
            pop[win_idx] = 1'b1;
            cdb_valid_d  = 1'b1;
            cdb_entry_d  = head[win_idx];
            rr_ptr_d     = RR_W'(rr_next(int'(win_idx), N_FU));
        end
    end

    // Broadcast register and round-robin pointer; idle cycles drive zeros.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_entry_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_entry_q <= cdb_entry_d;
        end
    end

    assign Cdb_valid        = cdb_valid_q;
    assign Cdb_rd_tag       = cdb_entry_q[TAG_W-1:0];
    assign Cdb_data         = cdb_entry_q[TAG_W +: DATA_W];
    assign Cdb_branch       = cdb_entry_q[TAG_W + DATA_W];
    assign Cdb_branch_taken = cdb_entry_q[TAG_W + DATA_W + 1];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the broadcast rules.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int TW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic          tk;
        logic          br;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } ent_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    fu_valid;
    logic [N-1:0]    fu_ready;
    logic [N*TW-1:0] fu_rd_tag;
    logic [N*DW-1:0] fu_data;
    logic [N-1:0]    fu_branch;
    logic [N-1:0]    fu_branch_taken;
    logic            Cdb_valid;
    logic [TW-1:0]   Cdb_rd_tag;
    logic [DW-1:0]   Cdb_data;
    logic            Cdb_branch;
    logic            Cdb_branch_taken;
    logic            cdb_pending;

    cdb_arbiter #(.N_FU(N), .DEPTH(D), .TAG_W(TW), .DATA_W(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .fu_valid         (fu_valid),
        .fu_ready         (fu_ready),
        .fu_rd_tag        (fu_rd_tag),
        .fu_data          (fu_data),
        .fu_branch        (fu_branch),
        .fu_branch_taken  (fu_branch_taken),
        .Cdb_valid        (Cdb_valid),
        .Cdb_rd_tag       (Cdb_rd_tag),
        .Cdb_data         (Cdb_data),
        .Cdb_branch       (Cdb_branch),
        .Cdb_branch_taken (Cdb_branch_taken),
        .cdb_pending      (cdb_pending)
    );

    always #5 clock = ~clock;

    ent_t          mq [N][$];   // model: contents of each FU queue
    ent_t          src[N][$];   // offers each FU still has to deliver
    int            m_rr;
    logic          e_valid;
    ent_t          e_out;
    logic [TW-1:0] bcast[$];    // tags actually seen on the CDB
    bit            saw_hold2;
    int            n_assert = 0;
    int            n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic ent_t mk(input int tag, input int data, input bit br, input bit tk);
        ent_t e;
        e.tag  = TW'(tag);
        e.data = DW'(data);
        e.br   = br;
        e.tk   = tk;
        return e;
    endfunction

    task automatic drive();
        ent_t e;
        for (int i = 0; i < N; i++) begin
            e           = (src[i].size() > 0) ? src[i][0] : '0;
            fu_valid[i] = (src[i].size() > 0);
            fu_rd_tag[i*TW +: TW] = e.tag;
            fu_data[i*DW +: DW]   = e.data;
            fu_branch[i]          = e.br;
            fu_branch_taken[i]    = e.tk;
        end
    endtask

    function automatic logic model_pending();
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr    = 0;
        e_valid = 1'b0;
        e_out   = '0;
    endtask

    task automatic check_out();
        chk("cdb_valid",   64'(Cdb_valid),        64'(e_valid));
        chk("cdb_tag",     64'(Cdb_rd_tag),       64'(e_out.tag));
        chk("cdb_data",    64'(Cdb_data),         64'(e_out.data));
        chk("cdb_branch",  64'(Cdb_branch),       64'(e_out.br));
        chk("cdb_taken",   64'(Cdb_branch_taken), 64'(e_out.tk));
        chk("cdb_pending", 64'(cdb_pending),      64'(model_pending()));
    endtask

    // One clock: present offers, check ready, step the model at the edge,
    // then check the broadcast registers.
    task automatic cycle();
        logic [N-1:0] acc;
        logic [N-1:0] exp_rdy;
        int           w;
        int           idx;
        drive();
        #1;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = (mq[i].size() < D) && !flush;
            acc[i]     = fu_valid[i] && exp_rdy[i];
        end
        chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
        if (fu_valid[2] && !fu_ready[2]) saw_hold2 = 1'b1;
        @(posedge clock);
        if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            e_valid = 1'b0;
            e_out   = '0;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (w < 0 && mq[idx].size() > 0) w = idx;
            end
            if (w >= 0) begin
                e_out   = mq[w].pop_front();
                e_valid = 1'b1;
                m_rr    = (w + 1) % N;
            end else begin
                e_out   = '0;
                e_valid = 1'b0;
            end
            for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(src[i][0]);
        end
        for (int i = 0; i < N; i++) if (acc[i]) void'(src[i].pop_front());
        #1;
        check_out();
        if (Cdb_valid) bcast.push_back(Cdb_rd_tag);
    endtask

    initial begin
        logic [TW-1:0] f2[$];
        int            k;
        reset = 1'b1;
        flush = 1'b0;
        model_clear();
        drive();
        #2;
        chk("reset_valid", 64'(Cdb_valid), 64'(0));
        chk("reset_ready", 64'(fu_ready), 64'(4'hf));
        chk("reset_pending", 64'(cdb_pending), 64'(0));
        #10 reset = 1'b0;

        // Reset while three entries are still queued.
        for (int i = 0; i < N; i++) src[i].push_back(mk(20 + i, 200 + i, 1'b1, 1'b1));
        cycle();
        cycle();
        chk("pre_reset_pending", 64'(cdb_pending), 64'(1));
        #3 reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(Cdb_valid), 64'(0));
        chk("async_rst_out", 64'({Cdb_rd_tag, Cdb_branch, Cdb_branch_taken}), 64'(0));
        chk("async_rst_data", 64'(Cdb_data), 64'(0));
        chk("async_rst_ready", 64'(fu_ready), 64'(4'hf));
        chk("async_rst_pending", 64'(cdb_pending), 64'(0));
        model_clear();
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) cycle();

        // All four FUs push together with the pointer at 0.
        for (int i = 0; i < N; i++) src[i].push_back(mk(i + 1, 100 + i, 1'b0, 1'b0));
        cycle();
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("t3_valid", 64'(Cdb_valid), 64'(1));
            chk("t3_tag", 64'(Cdb_rd_tag), 64'(c + 1));
        end
        cycle();
        chk("t3_idle", 64'(Cdb_valid), 64'(0));

        // Single push on FU0: one broadcast, then zeros.
        src[0].push_back(mk(3, 30, 1'b0, 1'b0));
        cycle();
        chk("t2_latency", 64'(Cdb_valid), 64'(0));
        cycle();
        chk("t2_valid", 64'(Cdb_valid), 64'(1));
        chk("t2_tag", 64'(Cdb_rd_tag), 64'(3));
        chk("t2_data", 64'(Cdb_data), 64'(30));
        cycle();
        chk("t2_clear", 64'({Cdb_valid, Cdb_rd_tag, Cdb_data}), 64'(0));

        // FU2 back-pressured while FU0/FU1 stay busy.
        bcast.delete();
        saw_hold2 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            src[0].push_back(mk(20 + t, t, 1'b0, 1'b0));
            src[1].push_back(mk(24 + t, t, 1'b0, 1'b0));
        end
        for (int t = 0; t < 3; t++) src[2].push_back(mk(10 + t, 50 + t, 1'b0, 1'b0));
        for (int c = 0; c < 25; c++) cycle();
        chk("t4_ready2_low", 64'(saw_hold2), 64'(1));
        chk("t4_total", 64'(bcast.size()), 64'(11));
        foreach (bcast[j]) if (bcast[j] >= 10 && bcast[j] <= 12) f2.push_back(bcast[j]);
        chk("t4_fu2_count", 64'(f2.size()), 64'(3));
        for (int j = 0; j < 3; j++) begin
            if (j < f2.size()) chk("t4_fu2_order", 64'(f2[j]), 64'(10 + j));
        end

        // Five pending entries discarded by a flush with all FUs offering.
        src[0].push_back(mk(13, 1, 1'b0, 1'b0));
        src[0].push_back(mk(17, 1, 1'b0, 1'b0));
        src[1].push_back(mk(14, 1, 1'b0, 1'b0));
        src[1].push_back(mk(18, 1, 1'b0, 1'b0));
        src[2].push_back(mk(15, 1, 1'b0, 1'b0));
        src[3].push_back(mk(16, 1, 1'b0, 1'b0));
        cycle();
        cycle();
        k = 0;
        for (int i = 0; i < N; i++) k += mq[i].size();
        chk("t5_five_pending", 64'(k), 64'(5));
        for (int i = 0; i < N; i++) src[i].push_back(mk(30 + i, 3, 1'b0, 1'b0));
        bcast.delete();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t5_valid", 64'(Cdb_valid), 64'(0));
        chk("t5_pending", 64'(cdb_pending), 64'(0));
        for (int i = 0; i < N; i++) src[i].delete();
        for (int c = 0; c < 4; c++) cycle();
        chk("t5_no_bcast", 64'(bcast.size()), 64'(0));

        // Branch result on FU1.
        src[1].push_back(mk(7, 0, 1'b1, 1'b1));
        cycle();
        cycle();
        chk("t6_tag", 64'(Cdb_rd_tag), 64'(7));
        chk("t6_branch", 64'({Cdb_branch, Cdb_branch_taken}), 64'(2'b11));
        cycle();
        chk("t6_idle", 64'({Cdb_valid, Cdb_branch, Cdb_branch_taken}), 64'(0));

        // Random traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src[i].size() == 0 && $urandom_range(0, 1) == 1)
                    src[i].push_back(mk(int'($urandom_range(0, 31)), int'($urandom),
                                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            end
            flush = ($urandom_range(0, 29) == 0);
            cycle();
            flush = 1'b0;
        end
        for (int i = 0; i < N; i++) src[i].delete();
        for (int c = 0; c < 12; c++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
